// File: rtl/map_tile_server_pkg.sv
// map_tile_server_pkg: shared tile codes, map geometry and requester indices for the tile-query path.
package map_tile_server_pkg;
   localparam int NUM_REQ  = 5;
   localparam int MAP_ROWS = 15;
   localparam int MAP_COLS = 20;
   localparam int NUM_MAPS = 4;
   localparam int COORD_W  = 10;
   localparam int ADDR_W   = COORD_W + 5;
   localparam int REQ_PLAYER = 0;
   localparam int REQ_MON0   = 1;
   localparam int REQ_MON1   = 2;
   localparam int REQ_MON2   = 3;
   localparam int REQ_MON3   = 4;
   typedef enum logic [2:0] {
      MAP_ROAD0  = 3'b000,
      MAP_ROAD1  = 3'b001,
      MAP_WALL   = 3'b010,
      MAP_STAIRS = 3'b011
   } tile_t;
   // (base + step) mod n for base, step < n
   function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] step, input logic [2:0] n);
      logic [3:0] s;
      s = {1'b0, base} + {1'b0, step};
      return (s >= {1'b0, n}) ? 3'(s - {1'b0, n}) : s[2:0];
   endfunction
endpackage

// File: rtl/map_tile_rom.sv
// map_tile_rom: per-map tile table with a registered one-cycle read; rows 0 and MAP_ROWS-1 are walls on every map.
module map_tile_rom
   import map_tile_server_pkg::*;
(
   input  logic              clk_13,
   input  logic              rst_n,
   input  logic [2:0]        map_id,
   input  logic [ADDR_W-1:0] addr,
   output logic [2:0]        tile
);
   logic [2:0] nxt;
   logic       border;
   always_comb begin
      border = (addr < ADDR_W'(MAP_COLS)) || (addr >= ADDR_W'((MAP_ROWS - 1) * MAP_COLS));
      nxt = border ? MAP_WALL : (addr[0] ? MAP_ROAD1 : MAP_ROAD0);
      case (map_id)
         3'd0: case (addr)
            15'd45:          nxt = MAP_STAIRS;
            15'd150, 15'd151: nxt = MAP_WALL;
            default: ;
         endcase
         3'd1: case (addr)
            15'd45:  nxt = MAP_WALL;
            15'd210: nxt = MAP_STAIRS;
            default: ;
         endcase
         3'd2: case (addr)
            15'd45:  nxt = MAP_ROAD0;
            15'd77:  nxt = MAP_STAIRS;
            15'd100: nxt = MAP_WALL;
            default: ;
         endcase
         3'd3: case (addr)
            15'd45:  nxt = MAP_WALL;
            15'd143: nxt = MAP_STAIRS;
            default: ;
         endcase
         default: ;
      endcase
   end
   always_ff @(posedge clk_13 or negedge rst_n)
      if (!rst_n) tile <= MAP_WALL;
      else        tile <= nxt;
endmodule

// File: rtl/map_tile_server.sv
// map_tile_server: round-robin tile-query responder, grant stage then ROM stage, fixed latency 2.
// MAP_TILE_SERVER_PLAYER_PRIO_EN: player always wins when eligible; monsters rotate among themselves.
module map_tile_server
   import map_tile_server_pkg::*;
(
   input  logic                       clk_13,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*COORD_W-1:0] req_r,
   input  logic [NUM_REQ*COORD_W-1:0] req_c,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [2:0]                 rsp_type,
   input  logic                       level_up,
   output logic [2:0]                 map_idx,
   output logic                       busy
);
   logic              a_vld, b_vld, a_oob, b_oob, gnt, oob;
   logic [2:0]        a_g, b_g, a_map, ptr, ptr_nxt, g, k, rom_tile;
   logic [ADDR_W-1:0] a_addr, lin;
   logic [COORD_W-1:0] r, c;
   logic [NUM_REQ-1:0] in_flight, elig;
   assign in_flight = ({NUM_REQ{a_vld}} & (NUM_REQ'(1) << a_g)) | ({NUM_REQ{b_vld}} & (NUM_REQ'(1) << b_g));
   assign elig = req_valid & ~in_flight;
   // Loops run from the far end of the rotation so the nearest eligible requester is the last write.
   always_comb begin
      gnt = 1'b0;
      g = '0;
      k = '0;
      ptr_nxt = ptr;
`ifdef MAP_TILE_SERVER_PLAYER_PRIO_EN
      for (int i = NUM_REQ - 2; i >= 0; i--) begin
         k = 3'd1 + rr_idx(ptr, 3'(i), 3'(NUM_REQ - 1));
         if (elig[k]) begin
            gnt = 1'b1;
            g = k;
         end
      end
      if (gnt) ptr_nxt = (g == 3'(NUM_REQ - 1)) ? 3'd0 : g;
      if (elig[REQ_PLAYER]) begin
         gnt = 1'b1;
         g = 3'(REQ_PLAYER);
         ptr_nxt = ptr;
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = rr_idx(ptr, 3'(i), 3'(NUM_REQ));
         if (elig[k]) begin
            gnt = 1'b1;
            g = k;
         end
      end
      if (gnt) ptr_nxt = rr_idx(g, 3'd1, 3'(NUM_REQ));
`endif
   end
   assign r   = req_r[g*COORD_W +: COORD_W];
   assign c   = req_c[g*COORD_W +: COORD_W];
   assign lin = ADDR_W'(r) * ADDR_W'(MAP_COLS) + ADDR_W'(c);
   assign oob = (r >= COORD_W'(MAP_ROWS)) || (c >= COORD_W'(MAP_COLS));
   always_ff @(posedge clk_13 or negedge rst_n)
      if (!rst_n) begin
         a_vld   <= 1'b0;
         b_vld   <= 1'b0;
         a_g     <= '0;
         b_g     <= '0;
         a_oob   <= 1'b0;
         b_oob   <= 1'b0;
         a_addr  <= '0;
         a_map   <= '0;
         ptr     <= '0;
         map_idx <= '0;
      end else begin
         a_vld <= gnt;
         if (gnt) begin
            a_g    <= g;
            a_addr <= oob ? '0 : lin;
            a_oob  <= oob;
            a_map  <= map_idx;
         end
         b_vld <= a_vld;
         b_g   <= a_g;
         b_oob <= a_oob;
         ptr   <= ptr_nxt;
         if (level_up && map_idx < 3'(NUM_MAPS - 1)) map_idx <= map_idx + 3'd1;
      end
   map_tile_rom u_rom (
      .clk_13(clk_13),
      .rst_n (rst_n),
      .map_id(a_map),
      .addr  (a_addr),
      .tile  (rom_tile)
   );
   assign rsp_valid = {NUM_REQ{b_vld}} & (NUM_REQ'(1) << b_g);
   assign rsp_type  = b_oob ? MAP_WALL : rom_tile;
   assign busy      = a_vld | b_vld;
endmodule

// File: tb/tb_map_tile_server.sv
// tb_map_tile_server: directed checks of latency, arbitration order, bounds, map switching and reset.
module tb_map_tile_server;
   import map_tile_server_pkg::*;
   logic clk_13 = 1'b0;
   logic rst_n = 1'b0;
   logic level_up = 1'b0;
   logic [NUM_REQ-1:0] req_valid = '0;
   logic [NUM_REQ-1:0] rsp_valid;
   logic [NUM_REQ*COORD_W-1:0] req_r = '0;
   logic [NUM_REQ*COORD_W-1:0] req_c = '0;
   logic [2:0] rsp_type, map_idx;
   logic busy;
   int vectors = 0;
   int miscompares = 0;
   logic [4:0] exp_v [8];
   logic [2:0] exp_t [8];
   always #5 clk_13 = ~clk_13;
   map_tile_server dut (
      .clk_13   (clk_13),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_r    (req_r),
      .req_c    (req_c),
      .rsp_valid(rsp_valid),
      .rsp_type (rsp_type),
      .level_up (level_up),
      .map_idx  (map_idx),
      .busy     (busy)
   );
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk_13);
   endtask
   task automatic set_rc(input int n, input int row, input int col);
      req_r[n*COORD_W +: COORD_W] = COORD_W'(row);
      req_c[n*COORD_W +: COORD_W] = COORD_W'(col);
   endtask
   task automatic set_all;
      set_rc(0, 3, 2);
      set_rc(1, 2, 5);
      set_rc(2, 0, 1023);
      set_rc(3, 1, 1);
      set_rc(4, 7, 10);
   endtask
   task automatic query(input int n, input int row, input int col, input logic [2:0] t, input string tag);
      set_rc(n, row, col);
      req_valid[n] = 1'b1;
      tick;
      chk({tag, "_busy_a"}, 8'(busy), 8'h01);
      chk({tag, "_early"}, 8'(rsp_valid), 8'h00);
      tick;
      chk({tag, "_rsp"}, 8'(rsp_valid), 8'(5'b1 << n));
      chk({tag, "_type"}, 8'(rsp_type), 8'(t));
      chk({tag, "_busy_b"}, 8'(busy), 8'h01);
      req_valid[n] = 1'b0;
      tick;
      chk({tag, "_done"}, 8'(rsp_valid), 8'h00);
      chk({tag, "_idle"}, 8'(busy), 8'h00);
   endtask
   // requesters not in hold drop their valid on seeing their response
   task automatic run_seq(input logic [4:0] hold, input string tag);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk($sformatf("%s_v%0d", tag, i), 8'(rsp_valid), 8'(exp_v[i]));
         if (exp_v[i] != 5'd0) chk($sformatf("%s_t%0d", tag, i), 8'(rsp_type), 8'(exp_t[i]));
         req_valid = req_valid & ~(exp_v[i] & ~hold);
      end
      req_valid = '0;
      tick;
      chk({tag, "_drain"}, 8'(busy), 8'h00);
   endtask
   initial begin
      tick;
      tick;
      chk("rst_rsp", 8'(rsp_valid), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      rst_n = 1'b1;
      tick;
      chk("rst_type", 8'(rsp_type), 8'h02);
      chk("rst_map", 8'(map_idx), 8'h00);
      chk("rst_busy2", 8'(busy), 8'h00);
      query(0, 3, 2, 3'b000, "p_road0");
      query(2, 0, 1023, 3'b010, "oob_cwrap");
      query(3, 1, 20, 3'b010, "oob_c20");
      query(3, 13, 19, 3'b001, "edge_13_19");
      query(4, 15, 0, 3'b010, "oob_r15");
      query(4, 7, 10, 3'b010, "m0_wall");
      // level_up one cycle after the grant must not change the in-flight answer
      set_rc(1, 2, 5);
      req_valid[1] = 1'b1;
      tick;
      level_up = 1'b1;
      chk("lu_busy", 8'(busy), 8'h01);
      tick;
      level_up = 1'b0;
      chk("lu_rsp", 8'(rsp_valid), 8'h02);
      chk("lu_type", 8'(rsp_type), 8'h03);
      chk("lu_map1", 8'(map_idx), 8'h01);
      req_valid[1] = 1'b0;
      tick;
      query(1, 2, 5, 3'b010, "map1_wall");
      level_up = 1'b1;
      tick;
      level_up = 1'b0;
      chk("lu_map2", 8'(map_idx), 8'h02);
      // grant and level_up on the same edge: query sees map 2
      req_valid[1] = 1'b1;
      level_up = 1'b1;
      tick;
      level_up = 1'b0;
      chk("same_map3", 8'(map_idx), 8'h03);
      tick;
      chk("same_rsp", 8'(rsp_valid), 8'h02);
      chk("same_type", 8'(rsp_type), 8'h00);
      req_valid[1] = 1'b0;
      tick;
      query(1, 2, 5, 3'b010, "map3_wall");
      query(1, 7, 3, 3'b011, "map3_stairs");
      for (int i = 0; i < 3; i++) begin
         level_up = 1'b1;
         tick;
         level_up = 1'b0;
         tick;
         chk($sformatf("sat_%0d", i), 8'(map_idx), 8'h03);
      end
      // reset with both pipeline stages occupied
      set_rc(0, 3, 2);
      set_rc(1, 2, 5);
      req_valid = 5'b00011;
      @(posedge clk_13);
      @(posedge clk_13);
      #1;
      rst_n = 1'b0;
      req_valid = '0;
      tick;
      chk("mid_rsp", 8'(rsp_valid), 8'h00);
      chk("mid_busy", 8'(busy), 8'h00);
      chk("mid_map", 8'(map_idx), 8'h00);
      chk("mid_type", 8'(rsp_type), 8'h02);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("post_rst_%0d", i), 8'(rsp_valid), 8'h00);
      end
      // all five held from a reset pointer: served 0..4, one per cycle
      set_all;
      exp_v = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00};
      exp_t = '{3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd2, 3'd0, 3'd0};
      req_valid = 5'b11111;
      run_seq(5'b00000, "all_held");
      // player keeps its valid high throughout while monsters are held until served
`ifdef MAP_TILE_SERVER_PLAYER_PRIO_EN
      exp_v = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h01, 5'h08, 5'h10, 5'h01};
      exp_t = '{3'd0, 3'd0, 3'd3, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
`else
      exp_v = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h00};
      exp_t = '{3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd2, 3'd0, 3'd0};
`endif
      req_valid = 5'b11111;
      run_seq(5'b00001, "p_held");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
